fpu_req_ctrl: RTL
=================

Name: fpu_req_ctrl

Overview:
- Sequential request/response controller that sits directly upstream of the combinational 32-bit FPU add/sub datapath and also consumes its result.
- Accepts operand requests over a valid/ready handshake and registers the op and both operands onto the FPU inputs.
- Holds them stable for a programmable multicycle window, captures the FPU result, and presents it over a valid/ready response handshake.
- Gives the combinational FPU a defined multicycle path and a clean pipeline interface.

Parameters:
- NUM_OP, 1, width of op select (0: ADD, 1: SUB); passed unchanged to the FPU.
- EXEC_CYCLES, 2, cycles operands are held before the result is captured; legal range 1..15.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_req_valid  input  1  request valid
- o_req_ready  output  1  request ready
- i_req_op  input  NUM_OP  requested operation
- i_req_a  input  32  operand A (IEEE-754 single)
- i_req_b  input  32  operand B
- o_fpu_op  output  NUM_OP  registered op to FPU i_alu_op
- o_fpu_a  output  32  registered operand to FPU i_data_a
- o_fpu_b  output  32  registered operand to FPU i_data_b
- i_fpu_result  input  32  FPU o_result
- o_rsp_valid  output  1  response valid
- i_rsp_ready  input  1  response ready
- o_rsp_result  output  32  captured result
- o_busy  output  1  high in EXEC or RESP

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n is low: state=IDLE, counter=0, and o_fpu_op/o_fpu_a/o_fpu_b/o_rsp_result=0, so o_rsp_valid=0, o_req_ready=0 and o_busy=0.
- Reset mid-operation aborts the operation. No response is produced for the in-flight request.
- FSM states are IDLE, EXEC, RESP.
- o_req_ready = (state==IDLE) | (state==RESP & i_rsp_ready). It is combinational and never depends on i_req_valid.
- Accept = i_req_valid & o_req_ready. On accept:
  - op/a/b are registered into the o_fpu_* registers;
  - the counter is loaded with EXEC_CYCLES-1;
  - the next state is EXEC.
- EXEC:
  - o_req_ready=0;
  - the counter decrements by 1 each cycle;
  - when the counter==0, i_fpu_result is registered into o_rsp_result and the next state is RESP.
- RESP:
  - o_rsp_valid=1, and o_rsp_result is held stable;
  - if i_rsp_ready and no accept, go to IDLE;
  - if i_rsp_ready and accept in the same cycle, go directly to EXEC (back-to-back, no bubble);
  - if i_rsp_ready is low, stay in RESP (stall) and ignore i_req_valid.
- Latency: a request accepted at clock edge T has its result captured at edge T+EXEC_CYCLES. o_rsp_valid is high from that edge onward. Minimum issue interval is EXEC_CYCLES+1 cycles.
- The o_fpu_* registers change only on accept and otherwise hold their values, including through RESP and IDLE. The FPU inputs are therefore stable for at least EXEC_CYCLES cycles before capture.
- Counter width is $clog2(EXEC_CYCLES+1) bits. It never wraps, because it is only decremented in EXEC while nonzero.
- o_busy = (state!=IDLE).
- Request inputs are don't-care when i_req_valid=0. i_rsp_ready is don't-care outside RESP.

Optional Feature:
- Macro: FPU_REQ_CTRL_FLAGS_EN.
- When defined, an extra output port o_rsp_flags [3:0] = {nan, inf, zero, neg} is registered at capture alongside o_rsp_result, reset to 0 and held with it:
  - nan = exp==8'hFF & frac!=0;
  - inf = exp==8'hFF & frac==0;
  - zero = exp==0 (denormals are flushed and count as zero);
  - neg = bit 31.
- When undefined, the port and its logic do not exist, and all other behaviour is identical.

Decomposition:
- Shared package fpu_pkg contains:
  - the state enum typedef (IDLE/EXEC/RESP);
  - localparams FP_EXP_W=8, FP_FRAC_W=23, FP_EXP_MAX=8'hFF;
  - op encodings OP_ADD=0, OP_SUB=1.
- One natural sub-module, fpu_result_classify: combinational, 32-bit in, 4 flags out, instantiated only under FPU_REQ_CTRL_FLAGS_EN.
- The FPU datapath itself is external and is wired at the top level.

Test Plan:
- Reset behaviour: hold i_rst_n=0 with i_req_valid=1 -> o_req_ready=0, o_rsp_valid=0, o_fpu_a=0. Release reset -> o_req_ready=1 in IDLE.
- Single ADD, EXEC_CYCLES=2: bench FPU model returns a+b; drive a=32'h3F800000, b=32'h40000000, op=0 at edge T -> o_rsp_valid rises at T+2, o_rsp_result=32'h40400000, o_busy=1 from T+1.
- Stall hold: i_rsp_ready=0 for 5 cycles while o_fpu_a is changed on the bench side -> o_rsp_result and o_rsp_valid stay constant, o_req_ready=0. Raise i_rsp_ready -> state returns to IDLE next edge.
- Back-to-back: in RESP assert i_rsp_ready=1 and i_req_valid=1 with a=32'h40400000, b=32'h3F800000, op=1 -> accept in the same cycle, o_rsp_valid deasserts for EXEC_CYCLES cycles, then o_rsp_result=32'h40000000.
- Mid-operation reset: pulse i_rst_n low during EXEC -> all outputs return to 0 asynchronously, and no response appears after release.
- Flags (macro defined): capture results 32'h7FC00000 -> flags=4'b1000; 32'hFF800000 -> 4'b0101; 32'h00000000 -> 4'b0010.

Source files
------------

// File: rtl/fpu_req_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU request controller slice.
//   state_t      : controller FSM states (IDLE / EXEC / RESP)
//   FP_*         : IEEE-754 single-precision field widths and the all-ones exponent
//   OP_ADD/OP_SUB: op-select encodings understood by the external FPU
// ---------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          FP_EXP_W   = 8;
    localparam int          FP_FRAC_W  = 23;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fpu_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// fpu_req_ctrl_if
// Request / response handshake bundle of fpu_req_ctrl.
//   i_req_valid, o_req_ready, i_req_op, i_req_a, i_req_b : request channel
//   o_rsp_valid, i_rsp_ready, o_rsp_result              : response channel
// modport slave  : the controller side
// modport master : the requester side
// ---------------------------------------------------------------------------
interface fpu_req_ctrl_if #(
    parameter int NUM_OP = 1
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic [NUM_OP-1:0] i_req_op;
    logic [31:0]       i_req_a;
    logic [31:0]       i_req_b;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [31:0]       o_rsp_result;

    modport slave (
        input  i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_result
    );

    modport master (
        output i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_result
    );
endinterface

// File: rtl/fpu_req_ctrl_classify.sv
// ---------------------------------------------------------------------------
// fpu_result_classify
// Combinational classification of a single-precision value.
//   i_value [31:0] : value to classify
//   o_flags [3:0]  : {nan, inf, zero, neg}
// Denormals (exponent 0) are reported as zero since the FPU flushes them.
// ---------------------------------------------------------------------------
module fpu_result_classify
    import fpu_pkg::*;
(
    input  logic [31:0] i_value,
    output logic [3:0]  o_flags
);
    logic [FP_EXP_W-1:0]  exp_f;
    logic [FP_FRAC_W-1:0] frac_f;

    assign exp_f  = i_value[30:23];
    assign frac_f = i_value[22:0];

    assign o_flags[3] = (exp_f == FP_EXP_MAX) && (frac_f != '0);
    assign o_flags[2] = (exp_f == FP_EXP_MAX) && (frac_f == '0);
    assign o_flags[1] = (exp_f == '0);
    assign o_flags[0] = i_value[31];
endmodule

// File: rtl/fpu_req_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_req_ctrl
// Sequencer in front of the combinational FPU add/sub datapath. Registers an
// accepted request onto the FPU inputs, holds them for EXEC_CYCLES cycles,
// captures the FPU result and offers it on the response handshake.
//
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   bus (slave)      : request/response handshake (fpu_req_ctrl_if)
//   o_fpu_op/a/b     : registered operands to the FPU
//   i_fpu_result     : FPU result
//   o_busy           : high in EXEC or RESP
//   o_rsp_flags[3:0] : {nan, inf, zero, neg} of the captured result, only
//                      present when FPU_REQ_CTRL_FLAGS_EN is defined
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, o_req_ready high
// EXEC  | operands held on the FPU, counter running down to 0
// RESP  | result captured and valid; may accept the next request
//       | in the same cycle the response is taken
// ---------------------------------------------------------------------------
module fpu_req_ctrl
    import fpu_pkg::*;
#(
    parameter int NUM_OP      = 1,
    parameter int EXEC_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    fpu_req_ctrl_if.slave     bus,
    output logic [NUM_OP-1:0] o_fpu_op,
    output logic [31:0]       o_fpu_a,
    output logic [31:0]       o_fpu_b,
    input  logic [31:0]       i_fpu_result,
`ifdef FPU_REQ_CTRL_FLAGS_EN
    output logic [3:0]        o_rsp_flags,
`endif
    output logic              o_busy
);
    localparam int CNT_W = $clog2(EXEC_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
        $error("fpu_req_ctrl: EXEC_CYCLES must be within 1..15");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rsp_valid;
    logic [31:0]      rsp_result;
    logic             req_ready;
    logic             accept;

    // Gated by reset so the requester never sees ready while the block is held.
    assign req_ready = i_rst_n &&
                       ((state == IDLE) || ((state == RESP) && bus.i_rsp_ready));
    assign accept    = bus.i_req_valid && req_ready;

    assign bus.o_req_ready  = req_ready;
    assign bus.o_rsp_valid  = rsp_valid;
    assign bus.o_rsp_result = rsp_result;

`ifdef FPU_REQ_CTRL_FLAGS_EN
    logic [3:0] flags_now;
    logic [3:0] flags_q;

    fpu_result_classify u_classify (
        .i_value (i_fpu_result),
        .o_flags (flags_now)
    );

    assign o_rsp_flags = flags_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            o_fpu_op   <= '0;
            o_fpu_a    <= '0;
            o_fpu_b    <= '0;
            rsp_result <= '0;
            rsp_valid  <= 1'b0;
            o_busy     <= 1'b0;
`ifdef FPU_REQ_CTRL_FLAGS_EN
            flags_q    <= '0;
`endif
        end else begin
            // Operand load is shared by IDLE and the back-to-back path in RESP.
            if (accept) begin
                o_fpu_op <= bus.i_req_op;
                o_fpu_a  <= bus.i_req_a;
                o_fpu_b  <= bus.i_req_b;
                cnt      <= CNT_LOAD;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= EXEC;
                        o_busy <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_result <= i_fpu_result;
`ifdef FPU_REQ_CTRL_FLAGS_EN
                        flags_q    <= flags_now;
`endif
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (accept) begin
                            state <= EXEC;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
